// File: rtl/mips_register_file.sv
`default_nettype none
// ============================================================================
// Module   : mips_register_file
// Brief    : 32 x 32 MIPS32 GPR file with two combinational read ports and one
//            synchronous write port; $0 reads as zero. Optional same-cycle
//            write-to-read forwarding when REGFILE_WRITE_BYPASS_EN is defined.
// Revision : 1.0
// ============================================================================
module mips_register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_REGS   = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [DATA_WIDTH-1:0] read_data_1,
   output logic [DATA_WIDTH-1:0] read_data_2,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [ADDR_WIDTH-1:0] read_reg_1,
   input  logic [ADDR_WIDTH-1:0] read_reg_2,
   input  logic [ADDR_WIDTH-1:0] write_reg,
   input  logic                  signal_reg_write
);

   localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = '0;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   logic [1:0][ADDR_WIDTH-1:0] rd_idx;
   logic [1:0][DATA_WIDTH-1:0] rd_data;

   logic write_en;

   // Writes aimed at $0 are dropped here so the stored zero never changes.
   assign write_en = signal_reg_write && (write_reg != ZERO_IDX);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (write_en) begin
         regs[write_reg] <= write_data;
      end
   end

   assign rd_idx[0]   = read_reg_1;
   assign rd_idx[1]   = read_reg_2;
   assign read_data_1 = rd_data[0];
   assign read_data_2 = rd_data[1];

   for (genvar p = 0; p < 2; p++) begin : g_read_port
      always_comb begin
         rd_data[p] = regs[rd_idx[p]];
         if (rd_idx[p] == ZERO_IDX) begin
            rd_data[p] = '0;
         end
`ifdef REGFILE_WRITE_BYPASS_EN
         else if (write_en && !reset && (write_reg == rd_idx[p])) begin
            rd_data[p] = write_data;
         end
`else
         else begin
            rd_data[p] = regs[rd_idx[p]];
         end
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mips_register_file.sv
`default_nettype none
// Self-checking bench for mips_register_file: directed scenarios followed by
// random traffic compared against an array-based reference model.
module tb_mips_register_file;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] read_data_1, read_data_2, write_data;
   logic [4:0]  read_reg_1, read_reg_2, write_reg;
   logic        signal_reg_write;

   int tests_run = 0;
   int tests_failed = 0;
   logic [31:0] model [32];

   mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32)) dut (
      .clk              (clk),
      .reset            (reset),
      .read_data_1      (read_data_1),
      .read_data_2      (read_data_2),
      .write_data       (write_data),
      .read_reg_1       (read_reg_1),
      .read_reg_2       (read_reg_2),
      .write_reg        (write_reg),
      .signal_reg_write (signal_reg_write)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] exp_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
      if (signal_reg_write && !reset && write_reg == idx) return write_data;
`endif
      return model[idx];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Clock edge with the model tracking what the register file must store.
   task automatic do_edge();
      logic        r, we;
      logic [4:0]  wr;
      logic [31:0] wd;
      r = reset; we = signal_reg_write; wr = write_reg; wd = write_data;
      @(posedge clk);
      #1;
      if (r) begin
         for (int i = 0; i < 32; i++) model[i] = 32'h0;
      end else if (we && wr != 5'd0) begin
         model[wr] = wd;
      end
   endtask

   task automatic check_all_zero(input string tag);
      signal_reg_write = 1'b0;
      for (int i = 0; i < 32; i++) begin
         read_reg_1 = i[4:0];
         read_reg_2 = 5'(31 - i);
         #1;
         check(tag, read_data_1, 32'h0);
         check(tag, read_data_2, 32'h0);
      end
   endtask

   initial begin
      logic [31:0] before_val;
      reset = 1'b1; signal_reg_write = 1'b0; write_reg = '0; write_data = '0;
      read_reg_1 = '0; read_reg_2 = 5'd1;
      for (int i = 0; i < 32; i++) model[i] = 32'hx;
      do_edge();
      reset = 1'b0;
      #1;
      check("reset_rd1_r0", read_data_1, 32'h0);
      check("reset_rd2_r1", read_data_2, 32'h0);
      check_all_zero("reset_all_zero");

      write_reg = 5'd2; write_data = 32'hFFFF_FFFF; signal_reg_write = 1'b1;
      do_edge();
      signal_reg_write = 1'b0; read_reg_1 = 5'd2; read_reg_2 = 5'd1;
      #1;
      check("basic_wr_r2", read_data_1, 32'hFFFF_FFFF);
      check("basic_wr_r1", read_data_2, 32'h0);

      write_reg = 5'd3; write_data = 32'h1234_5678; signal_reg_write = 1'b0;
      do_edge();
      read_reg_1 = 5'd3;
      #1;
      check("we_low_r3", read_data_1, 32'h0);

      write_reg = 5'd0; write_data = 32'hDEAD_BEEF; signal_reg_write = 1'b1;
      read_reg_1 = 5'd0;
      #1;
      check("r0_protect_pre", read_data_1, 32'h0);
      do_edge();
      signal_reg_write = 1'b0;
      #1;
      check("r0_protect_post", read_data_1, 32'h0);

      write_reg = 5'd5; write_data = 32'h1111_1111; signal_reg_write = 1'b1;
      do_edge();
      write_data = 32'h2222_2222; read_reg_1 = 5'd5; read_reg_2 = 5'd5;
      #1;
`ifdef REGFILE_WRITE_BYPASS_EN
      before_val = 32'h2222_2222;
`else
      before_val = 32'h1111_1111;
`endif
      check("same_cycle_pre", read_data_1, before_val);
      check("same_cycle_pre_p2", read_data_2, before_val);
      do_edge();
      signal_reg_write = 1'b0;
      #1;
      check("same_cycle_post", read_data_1, 32'h2222_2222);
      check("same_cycle_post_p2", read_data_2, 32'h2222_2222);

      reset = 1'b1; signal_reg_write = 1'b1; write_reg = 5'd2;
      write_data = 32'hAAAA_AAAA; read_reg_1 = 5'd2;
      #1;
      check("reset_midop_pre", read_data_1, 32'hFFFF_FFFF);
      do_edge();
      reset = 1'b0; signal_reg_write = 1'b0;
      #1;
      check("reset_prio_r2", read_data_1, 32'h0);
      check_all_zero("reset_prio_all");

      // Random traffic: mostly writes, occasional reset, reads on both ports.
      for (int n = 0; n < 400; n++) begin
         reset            = ($urandom_range(0, 31) == 0);
         signal_reg_write = ($urandom_range(0, 3) != 0);
         write_reg        = 5'($urandom_range(0, 31));
         write_data       = $urandom;
         read_reg_1       = ($urandom_range(0, 2) == 0) ? write_reg : 5'($urandom_range(0, 31));
         read_reg_2       = 5'($urandom_range(0, 31));
         #1;
         check("rand_pre_rd1", read_data_1, exp_read(read_reg_1));
         check("rand_pre_rd2", read_data_2, exp_read(read_reg_2));
         do_edge();
         reset = 1'b0; signal_reg_write = 1'b0;
         #1;
         check("rand_post_rd1", read_data_1, exp_read(read_reg_1));
         check("rand_post_rd2", read_data_2, exp_read(read_reg_2));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
